// File: rtl/noc_mapper_receiver_pkg.sv
// Shared definitions for the NoC mapper receive stage: flit field layout,
// packet FSM encoding and credit-vector layout.
package noc_mapper_receiver_pkg;

   // Packet FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BODY = 2'd1,
      ST_DROP = 2'd2
   } recv_state_e;

   // Pending-credit counter width; holds up to 7 outstanding credits
   localparam int CREDIT_CNT_BITS = 3;

   // Flit layout, LSB first: data | vc | dest | tail | valid
   function automatic int flit_vc_lsb(input int dw);
      return dw;
   endfunction

   function automatic int flit_dest_lsb(input int dw, input int vb);
      return dw + vb;
   endfunction

   function automatic int flit_tail_pos(input int dw, input int vb, input int db);
      return dw + vb + db;
   endfunction

   function automatic int flit_valid_pos(input int dw, input int vb, input int db);
      return dw + vb + db + 1;
   endfunction

   function automatic int flit_width(input int dw, input int vb, input int db);
      return dw + vb + db + 2;
   endfunction

   // Credit vector layout: {valid, vc}
   function automatic int credit_valid_pos(input int vb);
      return vb;
   endfunction

   function automatic int credit_width(input int vb);
      return vb + 1;
   endfunction

endpackage

// File: rtl/noc_mapper_receiver_fifo.sv
// First-word-fall-through flit buffer. A write is accepted when not full or
// when a read happens in the same cycle; the head entry is always visible on
// rd_data. Storage is cleared by reset so the head reads as zero afterwards.
module noc_mapper_receiver_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   // Next-state for storage, pointers (wrap naturally at DEPTH) and occupancy
   always_comb begin
      rd_ok    = rd_en && !empty;
      wr_ok    = wr_en && (!full || rd_ok);
      mem_d    = mem_q;
      if (wr_ok) begin
         mem_d[wr_ptr_q] = wr_data;
      end
      wr_ptr_d = wr_ptr_q + AW'(wr_ok);
      rd_ptr_d = rd_ptr_q + AW'(rd_ok);
      count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
   end

   // Register update with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/noc_mapper_receiver.sv
// Terminal NoC receive stage in front of a mapper. Buffers incoming flits in
// a FWFT FIFO, hands {data, last} to the mapper over valid/ready and returns
// one credit upstream per flit popped or dropped.
// Optional feature macro: NOC_RECV_DEST_CHECK_EN enables destination checking
// on head flits; misrouted packets are dropped (credits still returned) and
// err_misroute is set. Without it dest is ignored and err_misroute is 0.
//
// state | meaning
// IDLE  | waiting for a head flit
// BODY  | accepted packet in progress, pushing flits until tail
// DROP  | misrouted packet in progress, discarding flits until tail
module noc_mapper_receiver
   import noc_mapper_receiver_pkg::*;
#(
   parameter int FLIT_DATA_WIDTH = 32,
   parameter int DEST_BITS       = 2,
   parameter int VC_BITS         = 1,
   parameter int FIFO_DEPTH      = 4,
   parameter int MY_PORT         = 0
) (
   input  logic                                                     CLK,
   input  logic                                                     RST_N,
   input  logic [flit_width(FLIT_DATA_WIDTH, VC_BITS, DEST_BITS)-1:0] flit_in,
   output logic [credit_width(VC_BITS)-1:0]                         send_credit,
   output logic [FLIT_DATA_WIDTH-1:0]                               data_out,
   output logic                                                     data_valid,
   output logic                                                     data_last,
   input  logic                                                     data_ready,
   output logic [15:0]                                              pkt_count,
   output logic                                                     err_overflow,
   output logic                                                     err_misroute
);

   localparam int VC_LSB    = flit_vc_lsb(FLIT_DATA_WIDTH);
   localparam int DEST_LSB  = flit_dest_lsb(FLIT_DATA_WIDTH, VC_BITS);
   localparam int TAIL_POS  = flit_tail_pos(FLIT_DATA_WIDTH, VC_BITS, DEST_BITS);
   localparam int VALID_POS = flit_valid_pos(FLIT_DATA_WIDTH, VC_BITS, DEST_BITS);
   localparam int CR_VALID  = credit_valid_pos(VC_BITS);
   localparam int ENTRY_W   = FLIT_DATA_WIDTH + 1;
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int CB        = CREDIT_CNT_BITS;
   localparam logic [DEST_BITS-1:0] MY_DEST = DEST_BITS'(MY_PORT);

   logic                       flit_valid;
   logic                       flit_tail;
   logic [DEST_BITS-1:0]       flit_dest;
   logic [VC_BITS-1:0]         flit_vc;
   logic [FLIT_DATA_WIDTH-1:0] flit_data;

   assign flit_valid = flit_in[VALID_POS];
   assign flit_tail  = flit_in[TAIL_POS];
   assign flit_dest  = flit_in[DEST_LSB +: DEST_BITS];
   assign flit_vc    = flit_in[VC_LSB +: VC_BITS];
   assign flit_data  = flit_in[FLIT_DATA_WIDTH-1:0];

   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic [ENTRY_W-1:0] fifo_rd_data;

   recv_state_e  state_q, state_d;
   logic [CB-1:0] credit_q, credit_d;
   logic [15:0]  pkt_count_q, pkt_count_d;
   logic         err_overflow_q, err_overflow_d;

   logic pop;
   logic push_req;
   logic push;
   logic drop;
   logic overflow;
   logic misroute_hit;

   assign pop      = !fifo_empty && data_ready;
   assign push     = push_req && (!fifo_full || pop);
   assign overflow = push_req && fifo_full && !pop;

   // Packet FSM next state and per-flit push/drop decision
   always_comb begin
      state_d      = state_q;
      push_req     = 1'b0;
      drop         = 1'b0;
      misroute_hit = 1'b0;
      if (flit_valid) begin
         case (state_q)
            ST_IDLE: begin
`ifdef NOC_RECV_DEST_CHECK_EN
               if (flit_dest != MY_DEST) begin
                  drop         = 1'b1;
                  misroute_hit = 1'b1;
                  state_d      = flit_tail ? ST_IDLE : ST_DROP;
               end else begin
                  push_req = 1'b1;
                  state_d  = flit_tail ? ST_IDLE : ST_BODY;
               end
`else
               push_req = 1'b1;
               state_d  = flit_tail ? ST_IDLE : ST_BODY;
`endif
            end
            ST_BODY: begin
               push_req = 1'b1;
               if (flit_tail) state_d = ST_IDLE;
            end
            ST_DROP: begin
               drop = 1'b1;
               if (flit_tail) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Credit accounting and status counters; pop and drop may both add in one cycle
   always_comb begin
      credit_d       = credit_q + CB'(pop) + CB'(drop) - CB'(credit_q != '0);
      pkt_count_d    = pkt_count_q + 16'(pop && fifo_rd_data[FLIT_DATA_WIDTH]);
      err_overflow_d = err_overflow_q | overflow;
   end

`ifdef NOC_RECV_DEST_CHECK_EN
   logic err_misroute_q, err_misroute_d;
   assign err_misroute_d = err_misroute_q | misroute_hit;
   assign err_misroute   = err_misroute_q;

   // Sticky misroute flag
   always_ff @(posedge CLK) begin
      if (!RST_N) err_misroute_q <= 1'b0;
      else        err_misroute_q <= err_misroute_d;
   end

   logic unused_fields;
   assign unused_fields = ^{flit_vc, fifo_count};
`else
   assign err_misroute = 1'b0;

   logic unused_fields;
   assign unused_fields = ^{flit_vc, fifo_count, flit_dest, MY_DEST, misroute_hit};
`endif

   // FSM, credit counter and status registers
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q        <= ST_IDLE;
         credit_q       <= '0;
         pkt_count_q    <= '0;
         err_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         pkt_count_q    <= pkt_count_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   noc_mapper_receiver_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .wr_en   (push),
      .wr_data ({flit_tail, flit_data}),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign send_credit[CR_VALID]    = (credit_q != '0);
   assign send_credit[VC_BITS-1:0] = '0;
   assign data_valid   = !fifo_empty;
   assign data_out     = fifo_rd_data[FLIT_DATA_WIDTH-1:0];
   assign data_last    = !fifo_empty && fifo_rd_data[FLIT_DATA_WIDTH];
   assign pkt_count    = pkt_count_q;
   assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_noc_mapper_receiver.sv
// Directed bench for noc_mapper_receiver with default parameters.
module tb_noc_mapper_receiver;
   import noc_mapper_receiver_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [36:0] flit_in;
   logic [1:0]  send_credit;
   logic [31:0] data_out;
   logic        data_valid;
   logic        data_last;
   logic        data_ready;
   logic [15:0] pkt_count;
   logic        err_overflow;
   logic        err_misroute;

   int checks   = 0;
   int failures = 0;

   noc_mapper_receiver dut (
      .CLK          (clk),
      .RST_N        (rst_n),
      .flit_in      (flit_in),
      .send_credit  (send_credit),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .data_last    (data_last),
      .data_ready   (data_ready),
      .pkt_count    (pkt_count),
      .err_overflow (err_overflow),
      .err_misroute (err_misroute)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [36:0] mk(input logic tail, input logic [1:0] dest,
                                      input logic [31:0] word);
      return {1'b1, tail, dest, 1'b0, word};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n      = 1'b0;
      flit_in    = '0;
      data_ready = 1'b0;
      @(negedge clk);
      step();
      step();
      rst_n = 1'b1;
      chk("rst_valid",    32'(data_valid),   32'd0);
      chk("rst_last",     32'(data_last),    32'd0);
      chk("rst_data",     data_out,          32'd0);
      chk("rst_credit",   32'(send_credit),  32'd0);
      chk("rst_pkt",      32'(pkt_count),    32'd0);
      chk("rst_ovf",      32'(err_overflow), 32'd0);
      chk("rst_misroute", 32'(err_misroute), 32'd0);

      // Single-flit packet
      flit_in = mk(1'b1, 2'd0, 32'hDEADBEEF);
      step();
      flit_in = '0;
      chk("s1_valid",  32'(data_valid),  32'd1);
      chk("s1_last",   32'(data_last),   32'd1);
      chk("s1_data",   data_out,         32'hDEADBEEF);
      chk("s1_nocred", 32'(send_credit), 32'd0);
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      chk("s1_empty",  32'(data_valid),  32'd0);
      chk("s1_credit", 32'(send_credit), 32'b10);
      chk("s1_pkt",    32'(pkt_count),   32'd1);
      step();
      chk("s1_cred_end", 32'(send_credit), 32'd0);

      // Four-flit packet held back by the mapper
      flit_in = mk(1'b0, 2'd0, 32'h1); step();
      flit_in = mk(1'b0, 2'd0, 32'h2); step();
      flit_in = mk(1'b0, 2'd0, 32'h3); step();
      flit_in = mk(1'b1, 2'd0, 32'h4); step();
      chk("p4_valid",  32'(data_valid),  32'd1);
      chk("p4_head",   data_out,         32'h1);
      chk("p4_last",   32'(data_last),   32'd0);
      chk("p4_nocred", 32'(send_credit), 32'd0);

      // Fifth flit while full and no pop: lost, overflow flagged
      flit_in = mk(1'b1, 2'd0, 32'h55);
      step();
      flit_in = '0;
      chk("ovf_flag",   32'(err_overflow), 32'd1);
      chk("ovf_head",   data_out,          32'h1);
      chk("ovf_nocred", 32'(send_credit),  32'd0);

      // Drain: words in order, one credit per pop on consecutive cycles
      data_ready = 1'b1;
      step();
      chk("d1_data",   data_out,         32'h2);
      chk("d1_credit", 32'(send_credit), 32'b10);
      step();
      chk("d2_data",   data_out,         32'h3);
      chk("d2_credit", 32'(send_credit), 32'b10);
      step();
      chk("d3_data",   data_out,         32'h4);
      chk("d3_last",   32'(data_last),   32'd1);
      chk("d3_credit", 32'(send_credit), 32'b10);
      step();
      chk("d4_empty",  32'(data_valid),  32'd0);
      chk("d4_credit", 32'(send_credit), 32'b10);
      chk("d4_pkt",    32'(pkt_count),   32'd2);
      step();
      chk("d5_cred_end", 32'(send_credit), 32'd0);
      data_ready = 1'b0;

      // Reset in the middle of a buffered packet
      flit_in = mk(1'b0, 2'd0, 32'hA1); step();
      flit_in = mk(1'b0, 2'd0, 32'hA2); step();
      flit_in = '0;
      chk("mr_valid", 32'(data_valid), 32'd1);
      rst_n = 1'b0;
      step();
      chk("mr_empty",  32'(data_valid),   32'd0);
      chk("mr_credit", 32'(send_credit),  32'd0);
      chk("mr_fsm",    32'(dut.state_q),  32'(ST_IDLE));
      chk("mr_ovf",    32'(err_overflow), 32'd0);
      chk("mr_pkt",    32'(pkt_count),    32'd0);
      rst_n = 1'b1;

      // Fill, then push into the full FIFO while popping: accepted, no error
      flit_in = mk(1'b0, 2'd0, 32'h11); step();
      flit_in = mk(1'b0, 2'd0, 32'h12); step();
      flit_in = mk(1'b0, 2'd0, 32'h13); step();
      flit_in = mk(1'b1, 2'd0, 32'h14); step();
      chk("fp_head", data_out, 32'h11);
      flit_in    = mk(1'b1, 2'd0, 32'h15);
      data_ready = 1'b1;
      step();
      flit_in = '0;
      chk("fp_noovf",  32'(err_overflow), 32'd0);
      chk("fp_head2",  data_out,          32'h12);
      chk("fp_credit", 32'(send_credit),  32'b10);
      step();
      chk("fp_head3", data_out, 32'h13);
      step();
      chk("fp_head4", data_out,        32'h14);
      chk("fp_last4", 32'(data_last),  32'd1);
      step();
      chk("fp_head5", data_out,        32'h15);
      chk("fp_last5", 32'(data_last),  32'd1);
      chk("fp_pkt1",  32'(pkt_count),  32'd1);
      step();
      chk("fp_empty", 32'(data_valid), 32'd0);
      chk("fp_pkt2",  32'(pkt_count),  32'd2);
      step();

      // Packet addressed to another port, then a correctly addressed one
`ifdef NOC_RECV_DEST_CHECK_EN
      flit_in = mk(1'b0, 2'd1, 32'hB1); step();
      chk("mis1_valid",  32'(data_valid),  32'd0);
      chk("mis1_credit", 32'(send_credit), 32'b10);
      flit_in = mk(1'b0, 2'd1, 32'hB2); step();
      chk("mis2_valid",  32'(data_valid),  32'd0);
      chk("mis2_credit", 32'(send_credit), 32'b10);
      flit_in = mk(1'b1, 2'd1, 32'hB3); step();
      flit_in = '0;
      chk("mis3_valid",  32'(data_valid),   32'd0);
      chk("mis3_credit", 32'(send_credit),  32'b10);
      chk("mis_flag",    32'(err_misroute), 32'd1);
      step();
      chk("mis_cred_end", 32'(send_credit), 32'd0);
      flit_in = mk(1'b1, 2'd0, 32'hC1); step();
      flit_in = '0;
      chk("ok_data", data_out,        32'hC1);
      chk("ok_last", 32'(data_last),  32'd1);
      step();
      chk("ok_empty",  32'(data_valid),  32'd0);
      chk("ok_pkt",    32'(pkt_count),   32'd3);
      chk("ok_credit", 32'(send_credit), 32'b10);
`else
      flit_in = mk(1'b0, 2'd1, 32'hB1); step();
      chk("nd1_data", data_out,        32'hB1);
      chk("nd1_mis",  32'(err_misroute), 32'd0);
      flit_in = mk(1'b0, 2'd1, 32'hB2); step();
      chk("nd2_data",   data_out,         32'hB2);
      chk("nd2_credit", 32'(send_credit), 32'b10);
      flit_in = mk(1'b1, 2'd1, 32'hB3); step();
      flit_in = '0;
      chk("nd3_data", data_out,       32'hB3);
      chk("nd3_last", 32'(data_last), 32'd1);
      step();
      chk("nd_empty", 32'(data_valid), 32'd0);
      chk("nd_pkt",   32'(pkt_count),  32'd3);
      flit_in = mk(1'b1, 2'd0, 32'hC1); step();
      flit_in = '0;
      chk("ok_data", data_out, 32'hC1);
      step();
      chk("ok_empty",  32'(data_valid),   32'd0);
      chk("ok_pkt",    32'(pkt_count),    32'd4);
      chk("ok_credit", 32'(send_credit),  32'b10);
      chk("ok_mis",    32'(err_misroute), 32'd0);
`endif
      data_ready = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
